encode_reg_arith: RTL and testbench
===================================

ENCODE_REG_ARITH -- requirements
Module: encode_reg_arith

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning output buffer entries (power of two, 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning a request is presented.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block can accept a request this cycle.
REQ-006 The block SHALL have port in_kind, input, reg_arith_kind_t, the requested R-type operation.
REQ-007 The block SHALL have ports in_rd, in_rs1 and in_rs2, input, 5 each, the register indices.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_instr holds an encoded word.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the word this cycle.
REQ-010 The block SHALL have port out_instr, output, 32, the encoded RV32I R-type instruction word.
REQ-011 The block SHALL have port err, output, 1, a one-cycle pulse after an invalid kind is consumed.
REQ-012 The block SHALL have port err_count, output, 8, a saturating count of invalid kinds consumed.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid and in_ready are both high; a word SHALL be popped on a rising edge where out_valid and out_ready are both high.
REQ-014 The encoding SHALL be: [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode 0110011.
REQ-015 The funct3 field SHALL be: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
REQ-016 The funct7 field SHALL be 0100000 for sub and sra, and 0000000 for every other kind.
REQ-017 An accepted valid kind SHALL be encoded and written to the buffer tail in the same edge.
REQ-018 An accepted rak_invalid kind, or any unmapped kind value, SHALL be consumed without a buffer write.
REQ-019 After an invalid kind is consumed, err SHALL be high for exactly the next cycle, and err_count SHALL increment and hold at 255.
REQ-020 Latency SHALL be one cycle: a word accepted at edge N is visible on out_instr with out_valid high after edge N.
REQ-021 No combinational path SHALL run from in_* to out_*.
REQ-022 in_ready SHALL equal (count < DEPTH); it SHALL NOT depend on out_ready.
REQ-023 out_valid SHALL equal (count > 0), and out_instr SHALL show the head entry (FIFO order).
REQ-024 out_instr SHALL be 32'h0 when the buffer is empty.
REQ-025 A push and a pop on the same edge SHALL leave count unchanged, and the head SHALL advance correctly.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 Full status SHALL be distinguished from empty by a count or an extra pointer bit.
REQ-028 out_instr and out_valid SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-029 While rst is high at a clock edge, count, both pointers and err_count SHALL be set to 0 and err SHALL be set to 0.
REQ-030 During and after reset, out_valid SHALL be 0, out_instr 32'h0 and in_ready 1.
REQ-031 Reset asserted mid-operation SHALL discard all buffered words, and any handshake on that edge SHALL be ignored.

Structure
REQ-032 reg_arith_kind_t SHALL remain in package instr_type; OPCODE_OP (7'b0110011), FUNCT7_BASE (7'b0000000) and FUNCT7_ALT (7'b0100000) SHALL be added there.
REQ-033 The funct3/funct7 mapping SHALL be a pure combinational function, with no state.
REQ-034 The buffer SHALL be one sub-module, sync_fifo, parameterised by width (32) and DEPTH.

Verification
REQ-035 Add: rst 2 cycles, then add rd=1 rs1=2 rs2=3 with out_ready=1 -> out_valid high the next cycle, out_instr 32'h003100B3.
REQ-036 Sub then sra: sub rd=5 rs1=6 rs2=7, then sra rd=10 rs1=11 rs2=12 -> 32'h407302B3 then 32'h40C5D533, in order.
REQ-037 Fill and wrap: hold out_ready=0 and push 4 valid kinds -> in_ready low after the 4th; then pop 4 and push 3 more -> FIFO order preserved across the pointer wrap.
REQ-038 Invalid kind: push rak_invalid between two adds -> err pulses one cycle, err_count=1, only 2 words emitted; 300 invalid kinds -> err_count=255.
REQ-039 Simultaneous push/pop with count=2 -> count stays 2 and the head advances; stalling out_ready=0 for 5 cycles -> out_instr stable.
REQ-040 Mid-operation reset: assert rst with 3 words buffered -> next cycle out_valid=0, out_instr=0, in_ready=1, err_count=0.

Source files
------------

// File: rtl/encode_reg_arith_pkg.sv
// -----------------------------------------------------------------------------
// instr_type
//   Shared types and constants for RV32I register-register arithmetic
//   encoding. Holds the operation kind enum, the fixed opcode/funct7 values,
//   the funct3 codes and two pure helper functions:
//     map_fields  - kind -> {valid, funct7, funct3}; no state
//     pack_rtype  - assembles the 32-bit R-type word from fields and indices
// -----------------------------------------------------------------------------
package instr_type;

    // Requested R-type operation. Codes 11..15 are unmapped and are treated
    // exactly like rak_invalid by the encoder.
    typedef enum logic [3:0] {
        rak_invalid = 4'd0,
        rak_add     = 4'd1,
        rak_sub     = 4'd2,
        rak_sll     = 4'd3,
        rak_slt     = 4'd4,
        rak_sltu    = 4'd5,
        rak_xor     = 4'd6,
        rak_srl     = 4'd7,
        rak_sra     = 4'd8,
        rak_or      = 4'd9,
        rak_and     = 4'd10
    } reg_arith_kind_t;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    // Decoded instruction fields; valid is low for kinds that must not be
    // written into the output buffer.
    typedef struct packed {
        logic       valid;
        logic [6:0] funct7;
        logic [2:0] funct3;
    } arith_fields_t;

    // Pure kind -> field mapping. Anything not listed (rak_invalid and the
    // unmapped codes) falls into the default and is flagged invalid.
    function automatic arith_fields_t map_fields(input reg_arith_kind_t kind);
        arith_fields_t f;
        f.valid  = 1'b1;
        f.funct7 = FUNCT7_BASE;
        f.funct3 = FUNCT3_ADD_SUB;
        case (kind)
            rak_add:  f.funct3 = FUNCT3_ADD_SUB;
            rak_sub: begin
                f.funct3 = FUNCT3_ADD_SUB;
                f.funct7 = FUNCT7_ALT;
            end
            rak_sll:  f.funct3 = FUNCT3_SLL;
            rak_slt:  f.funct3 = FUNCT3_SLT;
            rak_sltu: f.funct3 = FUNCT3_SLTU;
            rak_xor:  f.funct3 = FUNCT3_XOR;
            rak_srl:  f.funct3 = FUNCT3_SRL_SRA;
            rak_sra: begin
                f.funct3 = FUNCT3_SRL_SRA;
                f.funct7 = FUNCT7_ALT;
            end
            rak_or:   f.funct3 = FUNCT3_OR;
            rak_and:  f.funct3 = FUNCT3_AND;
            default: begin
                f.valid  = 1'b0;
                f.funct7 = FUNCT7_BASE;
                f.funct3 = FUNCT3_ADD_SUB;
            end
        endcase
        return f;
    endfunction

    // R-type layout: funct7 | rs2 | rs1 | funct3 | rd | opcode.
    function automatic logic [31:0] pack_rtype(
        input arith_fields_t f,
        input logic [4:0]    rd,
        input logic [4:0]    rs1,
        input logic [4:0]    rs2
    );
        return {f.funct7, rs2, rs1, f.funct3, rd, OPCODE_OP};
    endfunction

endpackage

// File: rtl/encode_reg_arith_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with a fill counter (full vs. empty is told apart by the
//   counter, pointers wrap modulo DEPTH). Read data shows the head entry and
//   is forced to zero while the FIFO is empty. Empty/full flags are
//   registered, computed from the next fill level.
//
//   Parameters: WIDTH - entry width, DEPTH - entries (power of two, >= 2)
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset (clears level and pointers)
//     wr_en    in   write request (ignored when full)
//     wr_data  in   data to append at the tail
//     rd_en    in   pop request (ignored when empty)
//     rd_data  out  head entry, zero when empty
//     empty    out  no entries held
//     full     out  DEPTH entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] LVL_ONE   = CW'(1);
    localparam logic [CW-1:0] LVL_ZERO  = CW'(0);
    localparam logic [CW-1:0] LVL_FULL  = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             empty_r;
    logic             full_r;

    logic             do_push_s;
    logic             do_pop_s;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] rd_data_s;

    // Qualify requests against the current flags so an overflow or underflow
    // request can never corrupt the pointers.
    always_comb begin
        do_push_s = 1'b0;
        do_pop_s  = 1'b0;
        if (rst) begin
            do_push_s = 1'b0;
            do_pop_s  = 1'b0;
        end else begin
            do_push_s = wr_en && !full_r;
            do_pop_s  = rd_en && !empty_r;
        end
    end

    // Next fill level; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({do_push_s, do_pop_s})
            2'b10:   count_next_s = count_r + LVL_ONE;
            2'b01:   count_next_s = count_r - LVL_ONE;
            2'b11:   count_next_s = count_r;
            default: count_next_s = count_r;
        endcase
    end

    // Fill level, pointers and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r  <= LVL_ZERO;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            empty_r  <= 1'b1;
            full_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            empty_r <= (count_next_s == LVL_ZERO);
            full_r  <= (count_next_s == LVL_FULL);
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because the level gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Head entry, masked to zero when nothing is buffered.
    always_comb begin
        rd_data_s = '0;
        if (empty_r) begin
            rd_data_s = '0;
        end else begin
            rd_data_s = mem_r[rd_ptr_r];
        end
    end

    assign rd_data = rd_data_s;
    assign empty   = empty_r;
    assign full    = full_r;

endmodule

// File: rtl/encode_reg_arith.sv
// -----------------------------------------------------------------------------
// encode_reg_arith
//   Encodes RV32I register-register arithmetic requests into 32-bit R-type
//   words and queues them in a DEPTH-entry FIFO. Invalid or unmapped kinds are
//   consumed without producing a word; each one raises a one-cycle err pulse
//   and bumps a saturating 8-bit counter. Every output comes from state, so
//   there is no combinational path from in_* to out_*.
//
//   Parameter: DEPTH - output buffer entries (power of two, 2..16)
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     in_valid   in   request presented
//     in_ready   out  buffer has room (independent of out_ready)
//     in_kind    in   requested operation
//     in_rd      in   destination register index
//     in_rs1     in   first source register index
//     in_rs2     in   second source register index
//     out_valid  out  out_instr holds an encoded word
//     out_ready  in   consumer takes the head word this cycle
//     out_instr  out  head encoded word, zero when empty
//     err        out  one-cycle pulse after an invalid kind is consumed
//     err_count  out  saturating count of invalid kinds consumed
// -----------------------------------------------------------------------------
module encode_reg_arith
    import instr_type::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  reg_arith_kind_t in_kind,
    input  logic [4:0]      in_rd,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic            err,
    output logic [7:0]      err_count
);

    localparam logic [7:0] ERR_MAX = 8'd255;
    localparam logic [7:0] ERR_ONE = 8'd1;

    arith_fields_t fields_s;
    logic [31:0]   word_s;
    logic          accept_s;
    logic          push_s;
    logic          bad_kind_s;

    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic [31:0]   fifo_head_s;

    logic          err_r;
    logic [7:0]    err_count_r;

    // Decode the request and split an accepted request into either a buffer
    // write (valid kind) or an error event (invalid/unmapped kind).
    always_comb begin
        fields_s   = map_fields(in_kind);
        word_s     = pack_rtype(fields_s, in_rd, in_rs1, in_rs2);
        accept_s   = 1'b0;
        push_s     = 1'b0;
        bad_kind_s = 1'b0;
        if (in_valid && !fifo_full_s) begin
            accept_s   = 1'b1;
            push_s     = fields_s.valid;
            bad_kind_s = !fields_s.valid;
        end else begin
            accept_s   = 1'b0;
            push_s     = 1'b0;
            bad_kind_s = 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_s),
        .wr_data (word_s),
        .rd_en   (out_ready),
        .rd_data (fifo_head_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    // Error pulse and saturating error counter; reset wins over any
    // handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            err_r <= accept_s && bad_kind_s;
            if (accept_s && bad_kind_s && (err_count_r != ERR_MAX)) begin
                err_count_r <= err_count_r + ERR_ONE;
            end
        end
    end

    assign in_ready  = !fifo_full_s;
    assign out_valid = !fifo_empty_s;
    assign out_instr = fifo_head_s;
    assign err       = err_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_encode_reg_arith.sv
// -----------------------------------------------------------------------------
// tb_encode_reg_arith
//   Directed scenarios followed by randomized traffic. A queue-based model of
//   the encoder/FIFO is updated on every rising edge and compared against all
//   outputs on every falling edge; literal expectations pin known encodings.
// -----------------------------------------------------------------------------
module tb_encode_reg_arith;
    import instr_type::*;

    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    reg_arith_kind_t in_kind;
    logic [4:0]      in_rd;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic            err;
    logic [7:0]      err_count;

    int total = 0;
    int bad   = 0;
    bit checking = 1'b0;

    encode_reg_arith #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Kind code order: invalid, add, sub, sll, slt, sltu, xor, srl, sra, or, and
    int f3_tab [11] = '{0, 0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    int f7_tab [11] = '{0, 0, 32, 0, 0, 0, 0, 0, 32, 0, 0};

    logic [31:0] mq[$];
    bit          m_err = 1'b0;
    int          m_cnt = 0;

    function automatic bit kind_ok(int k);
        return (k >= 1) && (k <= 10);
    endfunction

    function automatic logic [31:0] ref_word(int k, int rd, int rs1, int rs2);
        longint w;
        w = longint'(f7_tab[k]) * 33554432 + longint'(rs2) * 1048576 + longint'(rs1) * 32768
            + longint'(f3_tab[k]) * 4096 + longint'(rd) * 128 + 51;
        return w[31:0];
    endfunction

    always @(posedge clk) begin
        int  k;
        bit  acc;
        bit  pop;
        k = int'(in_kind);
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
            m_cnt = 0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            pop = out_ready && (mq.size() > 0);
            if (pop) void'(mq.pop_front());
            m_err = 1'b0;
            if (acc) begin
                if (kind_ok(k)) begin
                    mq.push_back(ref_word(k, int'(in_rd), int'(in_rs1), int'(in_rs2)));
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output with the model on each falling edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < DEPTH)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
            chk("out_instr", out_instr, (mq.size() > 0) ? mq[0] : 32'h0);
            chk("err",       {31'd0, err},       {31'd0, m_err});
            chk("err_count", {24'd0, err_count}, 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(bit r, bit v, int k, int rd, int rs1, int rs2, bit ordy);
        logic [3:0] kb;
        kb        = k[3:0];
        rst       = r;
        in_valid  = v;
        in_kind   = reg_arith_kind_t'(kb);
        in_rd     = rd[4:0];
        in_rs1    = rs1[4:0];
        in_rs2    = rs2[4:0];
        out_ready = ordy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(bit ordy);
        drive(1'b0, 1'b0, 0, 0, 0, 0, ordy);
    endtask

    initial begin
        // reset for two cycles
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        checking = 1'b1;
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);

        // add rd=1 rs1=2 rs2=3
        drive(1'b0, 1'b1, 1, 1, 2, 3, 1'b1);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_word", out_instr, 32'h003100B3);
        idle(1'b1);

        // sub then sra, held until both buffered
        drive(1'b0, 1'b1, 2, 5, 6, 7, 1'b0);
        drive(1'b0, 1'b1, 8, 10, 11, 12, 1'b0);
        chk("sub_word", out_instr, 32'h407302B3);
        idle(1'b1);
        chk("sra_word", out_instr, 32'h40C5D533);
        idle(1'b1);

        // fill with out_ready low, then pop while pushing across the wrap
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1 + i, i, i + 1, i + 2, 1'b0);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, (i > 0), 5 + i, 20 + i, 3, 4, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // invalid between two adds
        drive(1'b0, 1'b1, 1, 1, 1, 1, 1'b1);
        drive(1'b0, 1'b1, 0, 2, 2, 2, 1'b1);
        chk("inv_err", {31'd0, err}, 32'd1);
        chk("inv_cnt", {24'd0, err_count}, 32'd1);
        drive(1'b0, 1'b1, 1, 3, 3, 3, 1'b1);
        chk("inv_err_drop", {31'd0, err}, 32'd0);
        idle(1'b1);

        // simultaneous push/pop at level 2, then a 5-cycle stall
        drive(1'b0, 1'b1, 3, 4, 5, 6, 1'b0);
        drive(1'b0, 1'b1, 4, 7, 8, 9, 1'b0);
        drive(1'b0, 1'b1, 9, 1, 2, 3, 1'b1);
        chk("pushpop_head", out_instr, ref_word(4, 7, 8, 9));
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("stall_head", out_instr, ref_word(4, 7, 8, 9));

        // mid-operation reset with three words buffered
        drive(1'b0, 1'b1, 10, 9, 9, 9, 1'b0);
        drive(1'b1, 1'b1, 1, 1, 1, 1, 1'b1);
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_instr", out_instr, 32'h0);
        chk("mrst_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_cnt", {24'd0, err_count}, 32'd0);

        // 300 invalid or unmapped kinds saturate the counter
        for (int i = 0; i < 300; i++)
            drive(1'b0, 1'b1, (i % 2 == 0) ? 0 : 11 + (i % 5), i, i, i, 1'b1);
        chk("sat_cnt", {24'd0, err_count}, 32'd255);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 10),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  ($urandom_range(0, 2) != 0));
        end
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
